// File: rtl/gpu_pkg.sv
// Shared GPU definitions: screen geometry, field widths and the queued pixel record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int COLOR_W  = 8;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;

  // One framebuffer write: linear address plus color.
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered count; head entry readable combinationally.
// Latency: a push is visible at dout_o the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports: clk/reset (sync, active-high); push_i/din_i write; pop_i read;
//        dout_o head entry; count_o occupancy (0..DEPTH); full_o/empty_o flags.
module pixel_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pixel_write_slave.sv
// Pixel-write responder: bounds-check, linearise, queue and drain pixels to frame memory.
// Latency: accept at edge N -> mem_we from cycle N+2; drawdone 1 cycle after final mem_ack.
// Backpressure: waitrequest while queue full (registered count) or in reset.
//
// Ports: clk/reset (sync, active-high); write/pixel_x/pixel_y/color/waitrequest initiator side;
//        shapedone in, drawdone out (shape complete); mem_we/mem_addr/mem_wdata/mem_ack memory
//        side; oob_count saturating count of dropped out-of-bounds pixels.
module pixel_write_slave
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write,
  input  logic [X_W-1:0]     pixel_x,
  input  logic [Y_W-1:0]     pixel_y,
  input  logic [COLOR_W-1:0] color,
  output logic               waitrequest,
  input  logic               shapedone,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ack,
  output logic               drawdone,
  output logic [7:0]         oob_count
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, ISSUE} drain_e;

  drain_e             state_q, state_d;
  pixel_t             push_pix, head_pix;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;
  logic               accept, in_bounds, push, pop;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [COLOR_W-1:0] mem_wdata_q;
  logic               pending_q, pending_d;
  logic [7:0]         oob_q;

  // Full is taken from the registered count, so a pop in this cycle does not
  // open a slot for this cycle's write.
  assign waitrequest = reset | fifo_full;
  assign accept      = write & ~waitrequest;
  assign in_bounds   = (pixel_x < X_W'(SCREEN_W)) && (pixel_y < Y_W'(SCREEN_H));
  assign push        = accept & in_bounds;

  assign push_pix.addr  = ADDR_W'(pixel_y) * ADDR_W'(SCREEN_W) + ADDR_W'(pixel_x);
  assign push_pix.color = color;

  pixel_fifo #(
    .W     ($bits(pixel_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_pix),
    .pop_i   (pop),
    .dout_o  (head_pix),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Drain FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Drain FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty)           state_d = ISSUE;
      ISSUE:   if (mem_ack && fifo_empty) state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Drain FSM: outputs. An ack with more queued work pops straight into the
  // next request, giving one write per cycle when memory acks immediately.
  always_comb begin
    pop    = 1'b0;
    mem_we = 1'b0;
    case (state_q)
      IDLE:  pop = !fifo_empty;
      ISSUE: begin
        mem_we = 1'b1;
        pop    = mem_ack & !fifo_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (pop) begin
      mem_addr_q  <= head_pix.addr;
      mem_wdata_q <= head_pix.color;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // A shape is done once nothing is queued and no request is outstanding.
  // A shapedone arriving with its last write sees that write already counted
  // in the queue next cycle, so it cannot fire early.
  assign drawdone  = ~reset & pending_q & (fifo_count == '0) & (state_q == IDLE);
  assign pending_d = shapedone | (pending_q & ~drawdone);

  always_ff @(posedge clk) begin
    if (reset) pending_q <= 1'b0;
    else       pending_q <= pending_d;
  end

  always_ff @(posedge clk) begin
    if (reset)                                      oob_q <= '0;
    else if (accept && !in_bounds && oob_q != 8'hFF) oob_q <= oob_q + 8'd1;
  end

  assign oob_count = oob_q;

endmodule

// File: tb/tb_pixel_write_slave.sv
module tb_pixel_write_slave;
  import gpu_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               write;
  logic [X_W-1:0]     pixel_x;
  logic [Y_W-1:0]     pixel_y;
  logic [COLOR_W-1:0] color;
  logic               waitrequest;
  logic               shapedone;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               mem_ack;
  logic               drawdone;
  logic [7:0]         oob_count;

  // memory responder controls and log of acknowledged writes {addr, data}
  logic        ack_en    = 1'b0;
  int          ack_delay = 0;
  logic        stray_ack = 1'b0;
  logic [26:0] log_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pixel_write_slave #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .write       (write),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .color       (color),
    .waitrequest (waitrequest),
    .shapedone   (shapedone),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .drawdone    (drawdone),
    .oob_count   (oob_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input int x, input int y, input int c);
    write   = w;
    pixel_x = X_W'(x);
    pixel_y = Y_W'(y);
    color   = COLOR_W'(c);
  endtask

  task automatic chk_entry(input string tag, input int idx, input int exp_addr, input int exp_data);
    logic [26:0] e;
    e = (idx < log_q.size()) ? log_q[idx] : '1;
    chk({tag, "_addr"}, 32'(e[26:8]), exp_addr);
    chk({tag, "_data"}, 32'(e[7:0]), exp_data);
  endtask

  // memory model: acks after ack_delay extra request cycles, logs each ack
  initial begin
    int wcnt;
    logic ack_gen;
    wcnt    = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ack_gen = 1'b0;
      if (mem_we && ack_en) begin
        if (wcnt == ack_delay) begin
          ack_gen = 1'b1;
          log_q.push_back({mem_addr, mem_wdata});
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      mem_ack = ack_gen | stray_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int cycles, ack_c, dd_c, dd_n, we_n;

    // ---------------- reset state
    reset = 1'b1;
    shapedone = 1'b0;
    drive(0, 0, 0, 0);
    next_cyc();
    next_cyc();
    mid();
    chk("rst_wreq",  32'(waitrequest), 1);
    chk("rst_we",    32'(mem_we), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_dd",    32'(drawdone), 0);
    chk("rst_oob",   32'(oob_count), 0);
    next_cyc();
    reset = 1'b0;

    // ---------------- single pixel, immediate ack, then shapedone
    ack_en = 1'b1;
    ack_delay = 0;
    drive(1, 3, 2, 'h5A);
    mid();
    chk("t1_wreq", 32'(waitrequest), 0);
    next_cyc();
    drive(0, 0, 0, 0);
    mid();
    chk("t1_we_early", 32'(mem_we), 0);
    next_cyc();
    shapedone = 1'b1;
    mid();
    chk("t1_we",    32'(mem_we), 1);
    chk("t1_addr",  32'(mem_addr), 1283);
    chk("t1_wdata", 32'(mem_wdata), 'h5A);
    chk("t1_ack",   32'(mem_ack), 1);
    chk("t1_dd_early", 32'(drawdone), 0);
    next_cyc();
    shapedone = 1'b0;
    mid();
    chk("t1_dd",      32'(drawdone), 1);
    chk("t1_we_done", 32'(mem_we), 0);
    next_cyc();
    mid();
    chk("t1_dd_once", 32'(drawdone), 0);
    chk("t1_log_n",   log_q.size(), 1);
    next_cyc();

    // ---------------- fill with acks held off
    log_q.delete();
    ack_en = 1'b0;
    drive(1, 0, 1, 'h10);          // occupies the request register
    mid();
    next_cyc();
    drive(0, 0, 0, 0);
    mid();
    next_cyc();
    for (int k = 0; k < 4; k++) begin
      drive(1, 10 + k, 1, 'h20 + k);
      mid();
      chk("t2_wreq_fill", 32'(waitrequest), 0);
      next_cyc();
    end
    drive(1, 14, 1, 'h24);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t2_wreq_full", 32'(waitrequest), 1);
      chk("t2_we_held",   32'(mem_we), 1);
      chk("t2_addr_held", 32'(mem_addr), 640);
      next_cyc();
    end
    ack_en = 1'b1;
    cycles = 0;
    forever begin
      mid();
      if (!waitrequest || cycles >= 10) break;
      next_cyc();
      cycles++;
    end
    chk("t2_wreq_release", cycles, 1);
    next_cyc();
    drive(1, 15, 1, 'h25);
    mid();
    chk("t2_wreq_6th", 32'(waitrequest), 0);
    next_cyc();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 40 && log_q.size() < 7; i++) next_cyc();
    chk("t2_log_n", log_q.size(), 7);
    chk_entry("t2_e0", 0, 640, 'h10);
    for (int k = 0; k < 6; k++) chk_entry("t2_ek", k + 1, 650 + k, 'h20 + k);

    // ---------------- out of bounds
    log_q.delete();
    drive(1, 640, 0, 1);
    mid();
    chk("t3_wreq", 32'(waitrequest), 0);
    next_cyc();
    drive(1, 0, 480, 2);
    mid();
    next_cyc();
    drive(0, 0, 0, 0);
    shapedone = 1'b1;
    mid();
    chk("t3_oob",      32'(oob_count), 2);
    chk("t3_dd_early", 32'(drawdone), 0);
    next_cyc();
    shapedone = 1'b0;
    mid();
    chk("t3_dd", 32'(drawdone), 1);
    chk("t3_we", 32'(mem_we), 0);
    next_cyc();
    mid();
    chk("t3_dd_once", 32'(drawdone), 0);
    drive(1, 1023, 511, 0);
    repeat (260) next_cyc();
    drive(0, 0, 0, 0);
    mid();
    chk("t3_oob_sat", 32'(oob_count), 255);
    chk("t3_log_n",   log_q.size(), 0);
    next_cyc();

    // ---------------- shapedone with last write, slow ack, corner pixel
    log_q.delete();
    ack_delay = 3;
    drive(1, 639, 479, 'hFF);
    shapedone = 1'b1;
    mid();
    next_cyc();
    drive(0, 0, 0, 0);
    shapedone = 1'b0;
    ack_c = -1;
    dd_c  = -1;
    dd_n  = 0;
    for (int i = 0; i < 20; i++) begin
      mid();
      if (mem_ack && ack_c < 0) ack_c = i;
      if (drawdone) begin
        dd_n++;
        if (dd_c < 0) dd_c = i;
      end
      next_cyc();
    end
    chk("t4_ack_cycle", ack_c, 4);
    chk("t4_dd_cycle",  dd_c, 5);
    chk("t4_dd_count",  dd_n, 1);
    chk("t4_log_n",     log_q.size(), 1);
    chk_entry("t4_e0", 0, 307199, 'hFF);

    // ---------------- reset mid-transfer with 3 queued
    log_q.delete();
    ack_en = 1'b0;
    ack_delay = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, k, 7, 'h30 + k);
      mid();
      chk("t5_wreq_fill", 32'(waitrequest), 0);
      next_cyc();
    end
    drive(0, 0, 0, 0);
    reset = 1'b1;
    mid();
    chk("t5_wreq_rst", 32'(waitrequest), 1);
    next_cyc();
    reset = 1'b0;
    ack_en = 1'b1;
    stray_ack = 1'b1;
    mid();
    chk("t5_we",    32'(mem_we), 0);
    chk("t5_addr",  32'(mem_addr), 0);
    chk("t5_wdata", 32'(mem_wdata), 0);
    chk("t5_oob",   32'(oob_count), 0);
    chk("t5_wreq",  32'(waitrequest), 0);
    next_cyc();
    stray_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t5_idle_we", 32'(mem_we), 0);
      chk("t5_idle_dd", 32'(drawdone), 0);
      next_cyc();
    end
    chk("t5_log_n", log_q.size(), 0);

    // ---------------- streaming, ack every cycle
    log_q.delete();
    we_n = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) drive(1, i, 5, 'h40 + i);
      else       drive(0, 0, 0, 0);
      mid();
      if (i < 8) chk("t6_wreq", 32'(waitrequest), 0);
      if (mem_we) we_n++;
      next_cyc();
    end
    chk("t6_we_cycles", we_n, 8);
    chk("t6_log_n", log_q.size(), 8);
    for (int k = 0; k < 8; k++) chk_entry("t6_ek", k, 3200 + k, 'h40 + k);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
